// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 sprite blitter.
package chip8_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW_A,
        ST_ROW_B,
        ST_ROW_D,
        ST_PIX_RD,
        ST_PIX_WR,
        ST_DONE
    } blit_state_e;

    localparam int ROW_CYC_NARROW = 2;
    localparam int ROW_CYC_WIDE   = 3;
    localparam int PIX_CYC        = 2;

    // Lit pixel value: all ones across the pixel width.
    function automatic logic [31:0] pixel_on(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/chip8_blitter_if.sv
// Memory-side bus of the blitter: sprite RAM read port and VRAM read/write port.
interface chip8_blitter_if #(
    parameter int ADDR_W  = 12,
    parameter int HPOS_W  = 7,
    parameter int VPOS_W  = 6,
    parameter int PIXEL_W = 2
);
    logic [ADDR_W-1:0]  ram_addr;
    logic [7:0]         ram_dout;
    logic [HPOS_W-1:0]  vram_hpos;
    logic [VPOS_W-1:0]  vram_vpos;
    logic [PIXEL_W-1:0] vram_pixelo;
    logic [PIXEL_W-1:0] vram_pixeli;
    logic               vram_we;

    modport master (
        output ram_addr, vram_hpos, vram_vpos, vram_pixeli, vram_we,
        input  ram_dout, vram_pixelo
    );

    modport slave (
        input  ram_addr, vram_hpos, vram_vpos, vram_pixeli, vram_we,
        output ram_dout, vram_pixelo
    );
endinterface

// File: rtl/chip8_blit_coord.sv
// One screen axis: origin + sprite offset, wrapped to the axis size, with a clip flag.
module chip8_blit_coord #(
    parameter int W = 7
) (
    input  logic [W-1:0] origin,
    input  logic [3:0]   offset,
    input  logic         wrap_en,
    output logic [W-1:0] coord,
    output logic         visible
);
    logic [W:0] sum;

    // The carry out of the axis width marks a pixel past the right/bottom edge.
    assign sum     = {1'b0, origin} + {{(W-3){1'b0}}, offset};
    assign coord   = sum[W-1:0];
    assign visible = wrap_en | ~sum[W];
endmodule

// File: rtl/chip8_blitter.sv
// Dxyn sprite draw engine: fetches sprite rows from RAM and XOR-draws them into VRAM.
// Handshake: start is sampled only in IDLE; busy covers the whole draw and done pulses in its final cycle.
module chip8_blitter
    import chip8_pkg::*;
#(
    parameter int SCREEN_W = 128,
    parameter int SCREEN_H = 64,
    parameter int ADDR_W   = 12,
    parameter int PIXEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        x,
    input  logic [7:0]        y,
    input  logic [3:0]        n,
    input  logic              wide_en,
    input  logic              wrap_en,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              collision,
    output blit_state_e       dbg_state,
    chip8_blitter_if.master   mem
);
    localparam int HPOS_W = $clog2(SCREEN_W);
    localparam int VPOS_W = $clog2(SCREEN_H);

    blit_state_e       state_q, state_d;
    logic [HPOS_W-1:0] ox_q;
    logic [VPOS_W-1:0] oy_q;
    logic [ADDR_W-1:0] base_q;
    logic              wrap_q;
    logic              wide_q;
    logic [4:0]        rows_q;
    logic [4:0]        row_q;
    logic [3:0]        col_q;
    logic [15:0]       sprite_q;
    logic              coll_q;

    logic [HPOS_W-1:0] h_coord;
    logic [VPOS_W-1:0] v_coord;
    logic              h_vis, v_vis;
    logic [3:0]        last_col;
    logic              last_row;
    logic [ADDR_W-1:0] row_addr;
    logic              pix_bit;
    logic              pix_lit;
    logic              write_hit;

    chip8_blit_coord #(.W(HPOS_W)) u_hcoord (
        .origin  (ox_q),
        .offset  (col_q),
        .wrap_en (wrap_q),
        .coord   (h_coord),
        .visible (h_vis)
    );

    chip8_blit_coord #(.W(VPOS_W)) u_vcoord (
        .origin  (oy_q),
        .offset  (row_q[3:0]),
        .wrap_en (wrap_q),
        .coord   (v_coord),
        .visible (v_vis)
    );

    assign last_col  = wide_q ? 4'd15 : 4'd7;
    assign last_row  = (row_q == rows_q - 5'd1);
    assign row_addr  = base_q + (wide_q ? ADDR_W'({row_q, 1'b0}) : ADDR_W'(row_q));
    // Sprite row is left-aligned in sprite_q, so column c maps to bit 15-c.
    assign pix_bit   = sprite_q[~col_q];
    assign pix_lit   = (mem.vram_pixelo != '0);
    assign write_hit = (state_q == ST_PIX_WR) && pix_bit && h_vis && v_vis;

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign collision = coll_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = (n == 4'd0 && !wide_en) ? ST_DONE : ST_ROW_A;
            ST_ROW_A:  state_d = wide_q ? ST_ROW_B : ST_ROW_D;
            ST_ROW_B:  state_d = ST_ROW_D;
            ST_ROW_D:  state_d = ST_PIX_RD;
            ST_PIX_RD: state_d = ST_PIX_WR;
            ST_PIX_WR: begin
                if (col_q != last_col) state_d = ST_PIX_RD;
                else if (last_row)     state_d = ST_DONE;
                else                   state_d = ST_ROW_A;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem.ram_addr    = '0;
        mem.vram_hpos   = '0;
        mem.vram_vpos   = '0;
        mem.vram_pixeli = '0;
        mem.vram_we     = 1'b0;
        case (state_q)
            ST_ROW_A: mem.ram_addr = row_addr;
            ST_ROW_B: mem.ram_addr = row_addr + ADDR_W'(1);
            ST_PIX_RD, ST_PIX_WR: begin
                mem.vram_hpos = h_coord;
                mem.vram_vpos = v_coord;
            end
            default: ;
        endcase
        // Gated by rst_n so the edge that samples reset never commits a write.
        mem.vram_we = write_hit && rst_n;
        if (write_hit)
            mem.vram_pixeli = pix_lit ? '0 : PIXEL_W'(pixel_on(PIXEL_W));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ox_q     <= '0;
            oy_q     <= '0;
            base_q   <= '0;
            wrap_q   <= 1'b0;
            wide_q   <= 1'b0;
            rows_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            sprite_q <= '0;
            coll_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (start) begin
                    ox_q   <= HPOS_W'(32'(x) % SCREEN_W);
                    oy_q   <= VPOS_W'(32'(y) % SCREEN_H);
                    base_q <= base_addr;
                    wrap_q <= wrap_en;
                    wide_q <= (n == 4'd0) && wide_en;
                    rows_q <= (n == 4'd0) ? 5'd16 : {1'b0, n};
                    row_q  <= '0;
                    col_q  <= '0;
                    coll_q <= 1'b0;
                end
                ST_ROW_B: sprite_q[15:8] <= mem.ram_dout;
                ST_ROW_D: begin
                    if (wide_q) sprite_q[7:0] <= mem.ram_dout;
                    else        sprite_q      <= {mem.ram_dout, 8'h00};
                    col_q <= '0;
                end
                ST_PIX_WR: begin
                    if (write_hit && pix_lit) coll_q <= 1'b1;
                    if (col_q == last_col) begin
                        col_q <= '0;
                        row_q <= row_q + 5'd1;
                    end else begin
                        col_q <= col_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_chip8_blitter.sv
// Directed bench for chip8_blitter with behavioural sprite RAM and VRAM models.
module tb_chip8_blitter;
    import chip8_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  x, y;
    logic [3:0]  n;
    logic        wide_en, wrap_en;
    logic [11:0] base_addr;
    logic        busy, done, collision;
    blit_state_e dbg_state;

    chip8_blitter_if #(.ADDR_W(12), .HPOS_W(7), .VPOS_W(6), .PIXEL_W(2)) mem_if ();

    chip8_blitter #(.SCREEN_W(128), .SCREEN_H(64), .ADDR_W(12), .PIXEL_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x         (x),
        .y         (y),
        .n         (n),
        .wide_en   (wide_en),
        .wrap_en   (wrap_en),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .collision (collision),
        .dbg_state (dbg_state),
        .mem       (mem_if.master)
    );

    always #5 clk = ~clk;

    logic [7:0] ram  [0:4095];
    logic [1:0] vram [0:63][0:127];
    int         write_cnt = 0;
    int         b2b_cnt   = 0;
    logic       prev_we   = 1'b0;
    int         n_checks  = 0;
    int         n_fail    = 0;

    // Memory models: 1-cycle read latency on both ports, VRAM written on the edge.
    always @(posedge clk) begin
        mem_if.ram_dout    <= ram[mem_if.ram_addr];
        mem_if.vram_pixelo <= vram[mem_if.vram_vpos][mem_if.vram_hpos];
        if (mem_if.vram_we) begin
            vram[mem_if.vram_vpos][mem_if.vram_hpos] <= mem_if.vram_pixeli;
            write_cnt++;
        end
        if (mem_if.vram_we && prev_we) b2b_cnt++;
        prev_we = mem_if.vram_we;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_vram();
        for (int v = 0; v < 64; v++)
            for (int h = 0; h < 128; h++)
                vram[v][h] = 2'd0;
    endtask

    function automatic logic [15:0] row_bits(input int yy, input int x0);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[15-i] = (vram[yy][(x0 + i) % 128] != 2'd0);
        return r;
    endfunction

    function automatic int lit_count();
        int c = 0;
        for (int v = 0; v < 64; v++)
            for (int h = 0; h < 128; h++)
                if (vram[v][h] != 2'd0) c++;
        return c;
    endfunction

    task automatic draw(input int xx, input int yy, input int nn, input logic wide, input logic wrap,
                        input int base, output int busy_cyc, output int writes, output logic first_done);
        int w0;
        @(negedge clk);
        x = 8'(xx); y = 8'(yy); n = 4'(nn);
        wide_en = wide; wrap_en = wrap; base_addr = 12'(base);
        start = 1'b1;
        w0 = write_cnt;
        @(negedge clk);
        start = 1'b0;
        first_done = done;
        busy_cyc = 0;
        while (busy && busy_cyc < 2000) begin
            busy_cyc++;
            @(negedge clk);
        end
        check_eq("busy_dropped", 32'(busy), 32'd0);
        writes = write_cnt - w0;
    endtask

    int   cyc, wr, w0, guard;
    logic fd;

    initial begin
        rst_n = 1'b0; start = 1'b0; x = '0; y = '0; n = '0;
        wide_en = 1'b0; wrap_en = 1'b0; base_addr = '0;
        for (int a = 0; a < 4096; a++) ram[a] = 8'h00;
        ram[12'h200] = 8'hF0;
        ram[12'h210] = 8'hFF;
        for (int a = 0; a < 32; a++) ram[12'h300 + a] = 8'hFF;
        clear_vram();
        repeat (3) @(negedge clk);

        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_coll", 32'(collision), 32'd0);
        check_eq("rst_we", 32'(mem_if.vram_we), 32'd0);
        check_eq("rst_pixeli", 32'(mem_if.vram_pixeli), 32'd0);
        check_eq("rst_ram_addr", 32'(mem_if.ram_addr), 32'd0);
        check_eq("rst_hpos", 32'(mem_if.vram_hpos), 32'd0);
        check_eq("rst_vpos", 32'(mem_if.vram_vpos), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Narrow draw on a blank screen.
        draw(10, 5, 1, 1'b0, 1'b1, 12'h200, cyc, wr, fd);
        check_eq("t1_busy_cyc", 32'(cyc), 32'd19);
        check_eq("t1_writes", 32'(wr), 32'd4);
        check_eq("t1_row", 32'(row_bits(5, 10)), 32'h0000F000);
        check_eq("t1_pix_val", 32'(vram[5][10]), 32'd3);
        check_eq("t1_coll", 32'(collision), 32'd0);

        // Identical redraw erases and collides.
        draw(10, 5, 1, 1'b0, 1'b1, 12'h200, cyc, wr, fd);
        check_eq("t2_writes", 32'(wr), 32'd4);
        check_eq("t2_row", 32'(row_bits(5, 10)), 32'h00000000);
        check_eq("t2_coll", 32'(collision), 32'd1);

        // Null draw clears collision and finishes immediately.
        draw(0, 0, 0, 1'b0, 1'b1, 12'h200, cyc, wr, fd);
        check_eq("null_first_done", 32'(fd), 32'd1);
        check_eq("null_busy_cyc", 32'(cyc), 32'd1);
        check_eq("null_writes", 32'(wr), 32'd0);
        check_eq("null_coll", 32'(collision), 32'd0);

        // Right-edge wrap and clip.
        clear_vram();
        draw(126, 20, 1, 1'b0, 1'b1, 12'h210, cyc, wr, fd);
        check_eq("wrap_writes", 32'(wr), 32'd8);
        check_eq("wrap_row", 32'(row_bits(20, 126)), 32'h0000FF00);
        clear_vram();
        draw(126, 20, 1, 1'b0, 1'b0, 12'h210, cyc, wr, fd);
        check_eq("clip_busy_cyc", 32'(cyc), 32'd19);
        check_eq("clip_writes", 32'(wr), 32'd2);
        check_eq("clip_row", 32'(row_bits(20, 126)), 32'h0000C000);

        // Wide 16x16 sprite.
        clear_vram();
        draw(50, 30, 0, 1'b1, 1'b1, 12'h300, cyc, wr, fd);
        check_eq("wide_busy_cyc", 32'(cyc), 32'd561);
        check_eq("wide_writes", 32'(wr), 32'd256);
        check_eq("wide_lit", 32'(lit_count()), 32'd256);
        check_eq("wide_top", 32'(row_bits(30, 50)), 32'h0000FFFF);
        check_eq("wide_bottom", 32'(row_bits(45, 50)), 32'h0000FFFF);
        check_eq("wide_below", 32'(row_bits(46, 50)), 32'h00000000);
        check_eq("wide_right", 32'(vram[30][66]), 32'd0);
        check_eq("wide_coll", 32'(collision), 32'd0);

        // Reset mid-row after three writes.
        clear_vram();
        @(negedge clk);
        x = 8'd20; y = 8'd10; n = 4'd1; wide_en = 1'b0; wrap_en = 1'b1; base_addr = 12'h210;
        start = 1'b1;
        w0 = write_cnt;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while ((write_cnt - w0) < 3 && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        check_eq("rst_mid_reached", 32'(write_cnt - w0), 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_we", 32'(mem_if.vram_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_mid_writes", 32'(write_cnt - w0), 32'd3);
        check_eq("rst_mid_row", 32'(row_bits(10, 20)), 32'h0000E000);

        draw(40, 12, 1, 1'b0, 1'b1, 12'h210, cyc, wr, fd);
        check_eq("after_rst_busy_cyc", 32'(cyc), 32'd19);
        check_eq("after_rst_writes", 32'(wr), 32'd8);
        check_eq("after_rst_row", 32'(row_bits(12, 40)), 32'h0000FF00);

        check_eq("no_b2b_we", 32'(b2b_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
